skewed_operand_feeder: RTL and testbench
========================================

SKEWED_OPERAND_FEEDER -- requirements
Module: skewed_operand_feeder

Interface
REQ-001 SHALL have parameter NUM_CH, default 32, meaning lane count (PE array rows or cols fed).
REQ-002 SHALL have parameter DWIDTH, default 8, meaning operand bits per lane.
REQ-003 SHALL have parameter DEPTH, default 32, meaning entries per lane FIFO; DEPTH_LOG2, default 5.
REQ-004 SHALL have parameter K_LOG2, default 9, meaning width of burst length.
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port START  input  1  burst start pulse, ignored while BUSY_out=1.
REQ-008 SHALL have port STALL  input  1  freezes all state while high.
REQ-009 SHALL have port K_SIZE_in  input  K_LOG2  vectors in burst, sampled on accepted START.
REQ-010 SHALL have port WR_VALID_in  input  1  write vector valid.
REQ-011 SHALL have port WR_DATA_in  input  NUM_CH*DWIDTH  vector; lane i at bits [i*DWIDTH +: DWIDTH].
REQ-012 SHALL have port WR_READY_out  output  1  vector accepted when WR_VALID_in & WR_READY_out at edge.
REQ-013 SHALL have port DATA_out  output  NUM_CH*DWIDTH  skewed operand per lane, registered.
REQ-014 SHALL have port VALID_out  output  NUM_CH  per-lane valid, registered.
REQ-015 SHALL have port BUSY_out  output  1  high in RUN or DRAIN.
REQ-016 SHALL have port DONE_out  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on START with K_SIZE_in!=0 and STALL=0.
REQ-018 SHALL, on START with K_SIZE_in=0 in IDLE, pulse DONE_out next cycle and stay IDLE with no VALID_out.
REQ-019 SHALL drive WR_READY_out = RUN & !STALL & accepted<K & lane NUM_CH-1 FIFO not full; same-cycle pop not credited.
REQ-020 SHALL push all NUM_CH lanes of an accepted vector into their lane FIFOs on the same edge.
REQ-021 SHALL pop lane 0 in any non-stalled RUN cycle where FIFO 0 nonempty and lane-0 pops<K.
REQ-022 SHALL pop lane i exactly i non-stalled cycles after each lane-0 pop (shift register of pop enables, advancing only when STALL=0).
REQ-023 SHALL give latency: vector accepted at edge n appears on lane i after edge n+1+i at earliest, VALID_out[i]=1 for exactly one non-stalled cycle per vector.
REQ-024 SHALL preserve order; no vector lost or duplicated under any STALL/backpressure pattern.
REQ-025 SHALL move RUN->DRAIN when lane 0 has popped K vectors; DRAIN->IDLE after lane NUM_CH-1 emits vector K-1, asserting DONE_out that cycle.
REQ-026 SHALL, while STALL=1, hold FSM, counters, FIFOs, pop shift register, DATA_out and VALID_out unchanged.
REQ-027 SHALL drive VALID_out[i]=0 on any non-stalled cycle lane i does not pop.
REQ-028 SHALL ignore WR_VALID_in outside RUN and after K vectors accepted.
REQ-029 SHALL use K_LOG2+1-bit counters so K=2^K_LOG2-1 does not wrap.

Reset
REQ-030 SHALL, on RSTn low, immediately clear DATA_out, VALID_out, WR_READY_out, BUSY_out, DONE_out to 0, empty all FIFOs, clear counters and pop shift register, enter IDLE.
REQ-031 SHALL, after reset mid-burst, accept a new START on the first cycle after RSTn rises.

Configuration
REQ-032 SHALL, with SKEW_FEEDER_ZERO_FILL_EN defined, drive lane i of DATA_out to 0 on every non-stalled cycle lane i does not pop.
REQ-033 SHALL, without SKEW_FEEDER_ZERO_FILL_EN, hold lane i of DATA_out at its last popped value when not popping.

Verification
REQ-034 SHALL verify reset: NUM_CH=4, RSTn low -> all outputs 0, BUSY_out=0.
REQ-035 SHALL verify burst: NUM_CH=4, DEPTH=4, K=3, vectors lane i=8'h10*j+i back-to-back from edge n -> lane i shows 8'h10*j+i after edge n+1+i+j; DONE_out after edge n+6.
REQ-036 SHALL verify stall: STALL high 10 cycles mid-burst -> outputs frozen, WR_READY_out=0; after release sequence resumes, no loss or duplication.
REQ-037 SHALL verify full: NUM_CH=4, DEPTH=2, K=8, STALL pulsed -> WR_READY_out drops when lane-3 FIFO holds 2; all 8 vectors emitted in order.
REQ-038 SHALL verify START K=0 -> DONE_out next cycle, VALID_out stays 0; START during BUSY_out=1 ignored.
REQ-039 SHALL verify RSTn pulse mid-burst -> outputs 0 asynchronously, new K=2 burst completes correctly; run with and without SKEW_FEEDER_ZERO_FILL_EN checking non-pop lane data.

Source files
------------

// File: rtl/skewed_operand_feeder.sv
// Skewed operand feeder: buffers NUM_CH-lane vectors and releases lane i exactly i cycles after lane 0.
// Optional build macro SKEW_FEEDER_ZERO_FILL_EN zeroes idle lanes instead of holding the last operand.
module skewed_operand_feeder #(
  parameter int NUM_CH     = 32,
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int K_LOG2     = 9
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     START,
  input  logic                     STALL,
  input  logic [K_LOG2-1:0]        K_SIZE_in,
  input  logic                     WR_VALID_in,
  input  logic [NUM_CH*DWIDTH-1:0] WR_DATA_in,
  output logic                     WR_READY_out,
  output logic [NUM_CH*DWIDTH-1:0] DATA_out,
  output logic [NUM_CH-1:0]        VALID_out,
  output logic                     BUSY_out,
  output logic                     DONE_out
);

  localparam int CW = K_LOG2 + 1;
  localparam int FW = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0]         FIFO_FULL = FW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST  = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
    return (p == PTR_LAST) ? '0 : p + DEPTH_LOG2'(1);
  endfunction

  function automatic logic [FW-1:0] fifo_cnt_next(input logic [FW-1:0] cnt,
                                                  input logic inc, input logic dec);
    return cnt + FW'(inc) - FW'(dec);
  endfunction

  state_t                state;
  logic [CW-1:0]         k_reg;
  logic [CW-1:0]         acc_cnt;
  logic [CW-1:0]         pop0_cnt;
  logic [CW-1:0]         popl_cnt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr   [NUM_CH];
  logic [FW-1:0]         fifo_cnt [NUM_CH];
  logic [DWIDTH-1:0]     mem      [NUM_CH][DEPTH];
  logic [NUM_CH-1:1]     pop_sr;
  logic [NUM_CH-1:0]     pop_en;
  logic                  push;
  logic                  pop0;
  logic                  lane0_last;
  logic                  lastlane_last;

  // Lane NUM_CH-1 pops last, so its FIFO is always the fullest and alone gates the writer.
  always_comb begin
    WR_READY_out  = (state == RUN) && !STALL && (acc_cnt < k_reg) &&
                    (fifo_cnt[NUM_CH-1] != FIFO_FULL);
    push          = WR_VALID_in && WR_READY_out;
    pop0          = (state == RUN) && !STALL && (fifo_cnt[0] != '0) && (pop0_cnt < k_reg);
    pop_en        = STALL ? '0 : {pop_sr, pop0};
    lane0_last    = pop0 && (pop0_cnt == k_reg - CW'(1));
    lastlane_last = pop_en[NUM_CH-1] && (popl_cnt == k_reg - CW'(1));
  end

  // Stage p0: control, counters, FIFO pointers and the pop-enable skew line
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      BUSY_out <= 1'b0;
      DONE_out <= 1'b0;
      k_reg    <= '0;
      acc_cnt  <= '0;
      pop0_cnt <= '0;
      popl_cnt <= '0;
      wr_ptr   <= '0;
      pop_sr   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr[i]   <= '0;
        fifo_cnt[i] <= '0;
      end
    end else if (!STALL) begin
      pop_sr   <= pop_en[NUM_CH-2:0];
      DONE_out <= 1'b0;
      if (push) begin
        acc_cnt <= acc_cnt + CW'(1);
        wr_ptr  <= ptr_inc(wr_ptr);
      end
      if (pop0)
        pop0_cnt <= pop0_cnt + CW'(1);
      if (pop_en[NUM_CH-1])
        popl_cnt <= popl_cnt + CW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        fifo_cnt[i] <= fifo_cnt_next(fifo_cnt[i], push, pop_en[i]);
        if (pop_en[i])
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
      end
      case (state)
        IDLE: begin
          if (START) begin
            k_reg    <= CW'(K_SIZE_in);
            acc_cnt  <= '0;
            pop0_cnt <= '0;
            popl_cnt <= '0;
            if (K_SIZE_in == '0) begin
              DONE_out <= 1'b1;
            end else begin
              state    <= RUN;
              BUSY_out <= 1'b1;
            end
          end
        end
        RUN: begin
          if (lastlane_last) begin
            state    <= IDLE;
            BUSY_out <= 1'b0;
            DONE_out <= 1'b1;
          end else if (lane0_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (lastlane_last) begin
            state    <= IDLE;
            BUSY_out <= 1'b0;
            DONE_out <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          BUSY_out <= 1'b0;
        end
      endcase
    end
  end

  // Lane storage carries data only, so it has no reset; emptiness lives in fifo_cnt.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int i = 0; i < NUM_CH; i++)
        mem[i][wr_ptr] <= WR_DATA_in[i*DWIDTH +: DWIDTH];
    end
  end

  // Stage p1: registered skewed operands
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      DATA_out  <= '0;
      VALID_out <= '0;
    end else if (!STALL) begin
      VALID_out <= pop_en;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_en[i])
          DATA_out[i*DWIDTH +: DWIDTH] <= mem[i][rd_ptr[i]];
`ifdef SKEW_FEEDER_ZERO_FILL_EN
        else
          DATA_out[i*DWIDTH +: DWIDTH] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_skewed_operand_feeder.sv
// Directed bench for skewed_operand_feeder: instance a (DEPTH=4) for burst/stall/reset, instance b (DEPTH=2) for full.
module tb_skewed_operand_feeder;

`ifdef SKEW_FEEDER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        a_start, a_stall, a_wv, a_wr, a_busy, a_done;
  logic [8:0]  a_k;
  logic [31:0] a_wd, a_do;
  logic [3:0]  a_vo;
  logic        b_start, b_stall, b_wv, b_wr, b_busy, b_done;
  logic [8:0]  b_k;
  logic [31:0] b_wd, b_do;
  logic [3:0]  b_vo;

  int errors = 0;
  int checks = 0;

  logic [3:0]  ev [8];
  logic [31:0] ed [8];
  logic [31:0] pv [8];

  skewed_operand_feeder #(.NUM_CH(4), .DWIDTH(8), .DEPTH(4), .DEPTH_LOG2(2), .K_LOG2(9)) u_a (
    .CLK(clk), .RSTn(rst_n), .START(a_start), .STALL(a_stall), .K_SIZE_in(a_k),
    .WR_VALID_in(a_wv), .WR_DATA_in(a_wd), .WR_READY_out(a_wr), .DATA_out(a_do),
    .VALID_out(a_vo), .BUSY_out(a_busy), .DONE_out(a_done));

  skewed_operand_feeder #(.NUM_CH(4), .DWIDTH(8), .DEPTH(2), .DEPTH_LOG2(1), .K_LOG2(9)) u_b (
    .CLK(clk), .RSTn(rst_n), .START(b_start), .STALL(b_stall), .K_SIZE_in(b_k),
    .WR_VALID_in(b_wv), .WR_DATA_in(b_wd), .WR_READY_out(b_wr), .DATA_out(b_do),
    .VALID_out(b_vo), .BUSY_out(b_busy), .DONE_out(b_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vec(input int j);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(16 * j + i);
    return v;
  endfunction

  task automatic set_step(input int k, input logic [3:0] v, input logic [31:0] dh,
                          input logic [31:0] dz);
    ev[k] = v;
    ed[k] = ZF ? dz : dh;
  endtask

  // Step k covers the edge that pushes pv[k] (k<np); a START pulse at step 2 must be ignored.
  task automatic run_seq(input string tag, input int nsteps, input int np, input int done_idx);
    for (int k = 0; k < nsteps; k++) begin
      if (k < np) begin
        a_wv = 1'b1;
        a_wd = pv[k];
        #1;
        chk({tag, "_wr_ready"}, a_wr, 1);
      end else begin
        a_wv = 1'b0;
        if (k == np) begin
          #1;
          chk({tag, "_wr_after_k"}, a_wr, 0);
        end
      end
      a_start = (k == 2);
      a_k     = 9'd5;
      tick();
      chk({tag, "_valid"}, a_vo, ev[k]);
      chk({tag, "_data"}, a_do, ed[k]);
      chk({tag, "_done"}, a_done, (k == done_idx));
      chk({tag, "_busy"}, a_busy, (k < done_idx));
    end
    a_start = 1'b0;
  endtask

  initial begin
    int          acc;
    bit          prev_stall;
    bit          done_seen;
    int          cnt_b [4];
    logic [7:0]  last_b [4];
    logic [7:0]  lane;

    rst_n = 1'b0;
    a_start = 0; a_stall = 0; a_k = '0; a_wv = 0; a_wd = '0;
    b_start = 0; b_stall = 0; b_k = '0; b_wv = 0; b_wd = '0;

    // Reset state
    #23;
    chk("rst_valid", a_vo, 0);
    chk("rst_data", a_do, 0);
    chk("rst_wr_ready", a_wr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_busy", b_busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back burst, K=3
    a_k = 9'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    pv[0] = vec(0); pv[1] = vec(1); pv[2] = vec(2);
    set_step(0, 4'b0000, 32'h00000000, 32'h00000000);
    set_step(1, 4'b0001, 32'h00000000, 32'h00000000);
    set_step(2, 4'b0011, 32'h00000110, 32'h00000110);
    set_step(3, 4'b0111, 32'h00021120, 32'h00021120);
    set_step(4, 4'b1110, 32'h03122120, 32'h03122100);
    set_step(5, 4'b1100, 32'h13222120, 32'h13220000);
    set_step(6, 4'b1000, 32'h23222120, 32'h23000000);
    set_step(7, 4'b0000, 32'h23222120, 32'h00000000);
    run_seq("burst", 8, 3, 6);

    // START with K=0
    a_k = 9'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("k0_done", a_done, 1);
    chk("k0_busy", a_busy, 0);
    chk("k0_valid", a_vo, 0);
    tick();
    chk("k0_done_end", a_done, 0);
    chk("k0_valid_end", a_vo, 0);
    chk("k0_busy_end", a_busy, 0);

    // Stall for 10 cycles mid-burst, K=4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_k = 9'd4; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a_wv = 1'b1;
      a_wd = vec(j);
      tick();
    end
    chk("stall_pre_valid", a_vo, 4'b0011);
    chk("stall_pre_data", a_do, 32'h00000110);
    a_stall = 1'b1;
    a_wd = vec(3);
    #1;
    chk("stall_wr_ready", a_wr, 0);
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("stall_valid_frozen", a_vo, 4'b0011);
      chk("stall_data_frozen", a_do, 32'h00000110);
      chk("stall_busy", a_busy, 1);
      chk("stall_wr_ready_low", a_wr, 0);
    end
    a_stall = 1'b0;
    pv[0] = vec(3);
    set_step(0, 4'b0111, 32'h00021120, 32'h00021120);
    set_step(1, 4'b1111, 32'h03122130, 32'h03122130);
    set_step(2, 4'b1110, 32'h13223130, 32'h13223100);
    set_step(3, 4'b1100, 32'h23323130, 32'h23320000);
    set_step(4, 4'b1000, 32'h33323130, 32'h33000000);
    set_step(5, 4'b0000, 32'h33323130, 32'h00000000);
    run_seq("stall_resume", 6, 1, 4);

    // Full lane FIFO with DEPTH=2, K=8, STALL pulsed
    b_k = 9'd8; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    acc = 0; prev_stall = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cnt_b[i]  = 0;
      last_b[i] = 8'h00;
    end
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (!prev_stall) begin
        for (int i = 0; i < 4; i++) begin
          lane = b_do[i*8 +: 8];
          if (b_vo[i]) begin
            chk("full_order", lane, 8'(16 * cnt_b[i] + i));
            last_b[i] = lane;
            cnt_b[i]++;
          end else begin
            chk("full_idle_lane", lane, ZF ? 8'h00 : last_b[i]);
          end
        end
        if (b_done) done_seen = 1;
      end
      b_stall = (cyc >= 8) && (cyc % 6 == 0);
      b_wv    = (acc < 8);
      b_wd    = vec(acc);
      #1;
      if (cyc == 1) chk("full_wr_first", b_wr, 1);
      if (cyc == 2 || cyc == 3) chk("full_wr_low", b_wr, 0);
      if (cyc == 5) chk("full_wr_back", b_wr, 1);
      if (b_wv && b_wr) acc++;
      prev_stall = b_stall;
      tick();
    end
    b_stall = 1'b0;
    b_wv    = 1'b0;
    chk("full_done_seen", done_seen, 1);
    for (int i = 0; i < 4; i++) chk("full_lane_count", cnt_b[i], 8);
    chk("full_accepted", acc, 8);
    chk("full_busy_end", b_busy, 0);

    // Asynchronous reset mid-burst, then a K=2 burst
    a_k = 9'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wv = 1'b1; a_wd = vec(0);
    tick();
    a_wd = vec(1);
    tick();
    rst_n = 1'b0;
    #2;
    chk("async_rst_valid", a_vo, 0);
    chk("async_rst_data", a_do, 0);
    chk("async_rst_wr_ready", a_wr, 0);
    chk("async_rst_busy", a_busy, 0);
    chk("async_rst_done", a_done, 0);
    a_wv = 1'b0;
    tick();
    rst_n = 1'b1;
    a_k = 9'd2; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    pv[0] = vec(4); pv[1] = vec(5);
    set_step(0, 4'b0000, 32'h00000000, 32'h00000000);
    set_step(1, 4'b0001, 32'h00000040, 32'h00000040);
    set_step(2, 4'b0011, 32'h00004150, 32'h00004150);
    set_step(3, 4'b0110, 32'h00425150, 32'h00425100);
    set_step(4, 4'b1100, 32'h43525150, 32'h43520000);
    set_step(5, 4'b1000, 32'h53525150, 32'h53000000);
    set_step(6, 4'b0000, 32'h53525150, 32'h00000000);
    run_seq("post_rst", 7, 2, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
